// File: rtl/wifi_irq_pkg.sv
// Shared types and constants for the WiFi interrupt scheduler.
// Holds the FSM encoding, source indices and default sizing.
package wifi_irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARB     = 2'd1,
    REQ     = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  localparam int SRC_RX     = 0;
  localparam int SRC_TX     = 1;
  localparam int SRC_BEACON = 2;
  localparam int SRC_LINK   = 3;

  localparam int NUM_SRC_DEFAULT        = 4;
  localparam int HOLDOFF_CYCLES_DEFAULT = 6250;  // 100 us at 62.5 MHz
  localparam int HOLD_W_DEFAULT         = 16;

  // A single source still needs a 1-bit vector field.
  function automatic int vec_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wifi_irq_scheduler_if.sv
// MSI request/grant handshake between the scheduler (master) and the MSI sink (slave).
interface wifi_irq_scheduler_if
  import wifi_irq_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEFAULT
);
  localparam int VEC_W = vec_width(NUM_SRC);

  logic             msi_req;
  logic [VEC_W-1:0] msi_vector;
  logic             msi_gnt;

  modport master (output msi_req, output msi_vector, input msi_gnt);
  modport slave  (input msi_req, input msi_vector, output msi_gnt);
endinterface

// File: rtl/wifi_rr_arbiter.sv
// Combinational rotate-priority picker: first eligible source strictly after
// last_grant, wrapping modulo NUM_SRC.
module wifi_rr_arbiter
  import wifi_irq_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEFAULT,
  parameter int VEC_W   = vec_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [VEC_W-1:0]   last_grant,
  output logic [VEC_W-1:0]   grant_idx,
  output logic               grant_any
);

  always_comb begin
    int               idx;
    logic [VEC_W-1:0] idx_v;
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    idx_v     = '0;
    for (int off = 1; off <= NUM_SRC; off++) begin
      idx = int'(last_grant) + off;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      idx_v = VEC_W'(idx);
      if (!grant_any && eligible[idx_v]) begin
        grant_any = 1'b1;
        grant_idx = idx_v;
      end
    end
  end

endmodule

// File: rtl/wifi_irq_scheduler.sv
// Latches event pulses into pending/in_service/overflow bits and issues one MSI
// at a time, round-robin over eligible sources, with a holdoff after each grant.
module wifi_irq_scheduler
  import wifi_irq_pkg::*;
#(
  parameter int NUM_SRC        = NUM_SRC_DEFAULT,
  parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEFAULT,
  parameter int HOLD_W         = HOLD_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   ev_pulse,
  input  logic                 irq_enable,
  input  logic [NUM_SRC-1:0]   irq_mask,
  input  logic                 ack_wr,
  input  logic [NUM_SRC-1:0]   ack_bits,
  wifi_irq_scheduler_if.master msi,
  output logic [NUM_SRC-1:0]   pending,
  output logic [NUM_SRC-1:0]   in_service,
  output logic [NUM_SRC-1:0]   overflow,
  output logic                 busy
);

  localparam int               VEC_W      = vec_width(NUM_SRC);
  localparam logic [VEC_W-1:0] LAST_RESET = VEC_W'(NUM_SRC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD =
    (HOLDOFF_CYCLES > 0) ? HOLD_W'(HOLDOFF_CYCLES - 1) : '0;

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [VEC_W-1:0]    last_grant;
  logic [VEC_W-1:0]    vec_q;
  logic                req_q;

  logic [NUM_SRC-1:0]  ack_mask;
  logic [NUM_SRC-1:0]  eligible;
  logic [NUM_SRC-1:0]  gnt_set;
  logic                gnt_accept;
  logic [VEC_W-1:0]    pick_idx;
  logic                pick_any;

  assign ack_mask   = ack_wr ? ack_bits : '0;
  assign eligible   = pending & ~irq_mask & ~in_service;
  assign gnt_accept = (state == REQ) && msi.msi_gnt;

  always_comb begin
    gnt_set = '0;
    if (gnt_accept) gnt_set[vec_q] = 1'b1;
  end

  wifi_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .VEC_W   (VEC_W)
  ) u_arb (
    .eligible   (eligible),
    .last_grant (last_grant),
    .grant_idx  (pick_idx),
    .grant_any  (pick_any)
  );

  // Event beats ack on pending; ack beats gnt on in_service and event on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      in_service <= '0;
      overflow   <= '0;
    end else begin
      // NOTE: non-blocking updates so every bit sees the pre-edge pending value.
      pending    <= (pending & ~ack_mask) | ev_pulse;
      in_service <= (in_service | gnt_set) & ~ack_mask;
      overflow   <= (overflow | (ev_pulse & pending)) & ~ack_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      last_grant <= LAST_RESET;
      vec_q      <= '0;
      req_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (irq_enable && (|eligible)) state <= ARB;
        end
        ARB: begin
          // Eligibility may vanish between IDLE and ARB through ack or mask.
          if (pick_any) begin
            vec_q      <= pick_idx;
            last_grant <= pick_idx;
            req_q      <= 1'b1;
            state      <= REQ;
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          // The request is held until granted, regardless of enable/mask/ack.
          if (msi.msi_gnt) begin
            req_q <= 1'b0;
            if (HOLDOFF_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              hold_cnt <= HOLD_LOAD;
              state    <= HOLDOFF;
            end
          end
        end
        HOLDOFF: begin
          if (hold_cnt == '0) state <= IDLE;
          else                hold_cnt <= hold_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign msi.msi_req    = req_q;
  assign msi.msi_vector = vec_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_wifi_irq_scheduler.sv
// Self-checking bench for wifi_irq_scheduler: scenario tasks plus a grant-time
// scoreboard of expected MSI vectors.
module tb_wifi_irq_scheduler;

  localparam int NUM_SRC = 4;
  localparam int HOLDOFF = 4;

  logic               clk;
  logic               rst_n;
  logic [NUM_SRC-1:0] ev_pulse;
  logic               irq_enable;
  logic [NUM_SRC-1:0] irq_mask;
  logic               ack_wr;
  logic [NUM_SRC-1:0] ack_bits;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] in_service;
  logic [NUM_SRC-1:0] overflow;
  logic               busy;

  wifi_irq_scheduler_if #(.NUM_SRC(NUM_SRC)) msi_if ();

  wifi_irq_scheduler #(
    .NUM_SRC        (NUM_SRC),
    .HOLDOFF_CYCLES (HOLDOFF),
    .HOLD_W         (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ev_pulse   (ev_pulse),
    .irq_enable (irq_enable),
    .irq_mask   (irq_mask),
    .ack_wr     (ack_wr),
    .ack_bits   (ack_bits),
    .msi        (msi_if),
    .pending    (pending),
    .in_service (in_service),
    .overflow   (overflow),
    .busy       (busy)
  );

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] sb_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every accepted request must match the next queued vector.
  always @(negedge clk) begin
    if (rst_n && msi_if.msi_req && msi_if.msi_gnt) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: vector %0d granted, none expected", msi_if.msi_vector);
      end else begin
        sb_exp = exp_q.pop_front();
        if (msi_if.msi_vector !== sb_exp) begin
          errors++;
          $display("FAIL sb_vector: got %0d expected %0d", msi_if.msi_vector, sb_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] bits);
    ev_pulse = bits;
    tick();
    ev_pulse = '0;
  endtask

  task automatic ack(input logic [NUM_SRC-1:0] bits);
    ack_wr   = 1'b1;
    ack_bits = bits;
    tick();
    ack_wr   = 1'b0;
    ack_bits = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({msi_if.msi_req, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_req_busy: got %b expected 00", {msi_if.msi_req, busy});
    end
    checks++;
    if ({pending, in_service, overflow} !== 12'h000) begin
      errors++;
      $display("FAIL reset_bits: got %h expected 000", {pending, in_service, overflow});
    end
    checks++;
    if (msi_if.msi_vector !== 2'd0) begin
      errors++;
      $display("FAIL reset_vector: got %0d expected 0", msi_if.msi_vector);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_event();
    int stray;
    irq_enable     = 1'b1;
    irq_mask       = '0;
    msi_if.msi_gnt = 1'b1;
    repeat (6) tick();
    exp_q.push_back(2'd0);
    pulse(4'b0001);
    checks++;
    if (pending !== 4'b0001 || msi_if.msi_req !== 1'b0) begin
      errors++;
      $display("FAIL single_n1: pending=%b req=%b expected 0001/0", pending, msi_if.msi_req);
    end
    tick();
    checks++;
    if (msi_if.msi_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_n2: req=%b busy=%b expected 0/1", msi_if.msi_req, busy);
    end
    tick();
    checks++;
    if (msi_if.msi_req !== 1'b1 || msi_if.msi_vector !== 2'd0) begin
      errors++;
      $display("FAIL single_n3: req=%b vec=%0d expected 1/0", msi_if.msi_req, msi_if.msi_vector);
    end
    tick();
    checks++;
    if (msi_if.msi_req !== 1'b0 || in_service !== 4'b0001) begin
      errors++;
      $display("FAIL single_n4: req=%b in_service=%b expected 0/0001", msi_if.msi_req, in_service);
    end
    stray = 0;
    repeat (15) begin
      tick();
      if (msi_if.msi_req !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL single_no_rerequest: %0d request cycles, expected 0", stray);
    end
    ack(4'b0001);
    checks++;
    if (pending !== 4'b0000 || in_service !== 4'b0000) begin
      errors++;
      $display("FAIL single_ack: pending=%b in_service=%b expected 0000/0000", pending, in_service);
    end
  endtask

  task automatic test_round_robin();
    int starts[$];
    logic prev;
    do_reset();
    msi_if.msi_gnt = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) exp_q.push_back(2'(i));
    pulse(4'b1111);
    prev = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      if (msi_if.msi_req === 1'b1 && prev === 1'b0) starts.push_back(t);
      prev = msi_if.msi_req;
      tick();
    end
    checks++;
    if (starts.size() != 4) begin
      errors++;
      $display("FAIL rr_count: got %0d requests expected 4", starts.size());
    end else begin
      checks++;
      if (starts[0] != 3) begin
        errors++;
        $display("FAIL rr_first: got cycle %0d expected 3", starts[0]);
      end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (starts[k] - starts[k-1] != 3 + HOLDOFF) begin
          errors++;
          $display("FAIL rr_spacing%0d: got %0d expected %0d", k, starts[k] - starts[k-1], 3 + HOLDOFF);
        end
      end
    end
    checks++;
    if (in_service !== 4'b1111) begin
      errors++;
      $display("FAIL rr_in_service: got %b expected 1111", in_service);
    end
    ack(4'b1111);
    repeat (8) tick();
  endtask

  task automatic test_hold();
    int unstable;
    msi_if.msi_gnt = 1'b0;
    exp_q.push_back(2'd1);
    pulse(4'b0010);
    repeat (2) tick();
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      if (msi_if.msi_req !== 1'b1 || msi_if.msi_vector !== 2'd1) unstable++;
      if (i == 5) begin
        irq_enable = 1'b0;
        irq_mask   = 4'b0010;
      end
      tick();
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL hold_stable: %0d unstable cycles, expected 0", unstable);
    end
    msi_if.msi_gnt = 1'b1;
    tick();
    msi_if.msi_gnt = 1'b0;
    checks++;
    if (msi_if.msi_req !== 1'b0 || in_service !== 4'b0010) begin
      errors++;
      $display("FAIL hold_grant: req=%b in_service=%b expected 0/0010", msi_if.msi_req, in_service);
    end
    irq_enable = 1'b1;
    irq_mask   = '0;
    ack(4'b0010);
    repeat (8) tick();
  endtask

  task automatic test_overflow_race();
    bit seen;
    irq_enable     = 1'b0;
    msi_if.msi_gnt = 1'b0;
    pulse(4'b0100);
    tick();
    pulse(4'b0100);
    checks++;
    if (overflow !== 4'b0100 || pending !== 4'b0100) begin
      errors++;
      $display("FAIL ovf_set: overflow=%b pending=%b expected 0100/0100", overflow, pending);
    end
    ev_pulse = 4'b0100;
    ack(4'b0100);
    ev_pulse = '0;
    checks++;
    if ({pending, in_service, overflow} !== {4'b0100, 4'b0000, 4'b0000}) begin
      errors++;
      $display("FAIL ovf_race: got %b/%b/%b expected 0100/0000/0000", pending, in_service, overflow);
    end
    exp_q.push_back(2'd2);
    msi_if.msi_gnt = 1'b1;
    irq_enable     = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (msi_if.msi_req === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || msi_if.msi_vector !== 2'd2) begin
      errors++;
      $display("FAIL ovf_rerequest: seen=%0b vec=%0d expected 1/2", seen, msi_if.msi_vector);
    end
    tick();
    ack(4'b0100);
    repeat (8) tick();
  endtask

  task automatic test_mask();
    int stray;
    irq_enable     = 1'b1;
    msi_if.msi_gnt = 1'b1;
    irq_mask       = 4'b0010;
    pulse(4'b0010);
    checks++;
    if (pending !== 4'b0010) begin
      errors++;
      $display("FAIL mask_pending: got %b expected 0010", pending);
    end
    stray = 0;
    repeat (10) begin
      tick();
      if (msi_if.msi_req !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL mask_blocked: %0d request cycles, expected 0", stray);
    end
    exp_q.push_back(2'd1);
    irq_mask = '0;
    tick();
    checks++;
    if (msi_if.msi_req !== 1'b0) begin
      errors++;
      $display("FAIL mask_early: req=%b expected 0", msi_if.msi_req);
    end
    tick();
    checks++;
    if (msi_if.msi_req !== 1'b1 || msi_if.msi_vector !== 2'd1) begin
      errors++;
      $display("FAIL mask_release: req=%b vec=%0d expected 1/1", msi_if.msi_req, msi_if.msi_vector);
    end
    tick();
    ack(4'b0010);
    repeat (8) tick();
  endtask

  task automatic test_async_reset();
    msi_if.msi_gnt = 1'b0;
    irq_enable     = 1'b1;
    pulse(4'b0010);
    repeat (2) tick();
    checks++;
    if (msi_if.msi_req !== 1'b1 || msi_if.msi_vector !== 2'd1) begin
      errors++;
      $display("FAIL areset_pre: req=%b vec=%0d expected 1/1", msi_if.msi_req, msi_if.msi_vector);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({msi_if.msi_req, busy, pending} !== 6'b000000 || msi_if.msi_vector !== 2'd0) begin
      errors++;
      $display("FAIL areset_immediate: req=%b busy=%b pending=%b vec=%0d expected 0/0/0000/0",
               msi_if.msi_req, busy, pending, msi_if.msi_vector);
    end
    tick();
    rst_n          = 1'b1;
    msi_if.msi_gnt = 1'b1;
    tick();
    for (int i = 0; i < NUM_SRC; i++) exp_q.push_back(2'(i));
    pulse(4'b1111);
    repeat (35) tick();
    checks++;
    if (in_service !== 4'b1111) begin
      errors++;
      $display("FAIL areset_rr: in_service=%b expected 1111", in_service);
    end
    ack(4'b1111);
    checks++;
    if (pending !== 4'b0000 || in_service !== 4'b0000) begin
      errors++;
      $display("FAIL areset_ack: pending=%b in_service=%b expected 0000/0000", pending, in_service);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    ev_pulse       = '0;
    irq_enable     = 1'b0;
    irq_mask       = '0;
    ack_wr         = 1'b0;
    ack_bits       = '0;
    msi_if.msi_gnt = 1'b0;

    test_reset();
    test_single_event();
    test_round_robin();
    test_hold();
    test_overflow_race();
    test_mask();
    test_async_reset();

    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected grants never seen", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
